// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions: channel opcodes and the transfer size
// used by the 32-bit TL blocks.
package tl_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    // log2 of the byte count of one 32-bit word transfer
    localparam logic [1:0] TlSizeWord = 2'd2;

endpackage

// File: rtl/tl_bram_host.sv
// Single-outstanding bridge from a word request/response port to a
// TileLink-UL host link. All outputs are registers or state decode.
module tl_bram_host
    import tl_pkg::*;
#(
    parameter int                     AddrWidth   = 12,
    parameter int                     SourceWidth = 1,
    parameter logic [SourceWidth-1:0] SourceId    = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [AddrWidth-3:0]   req_addr_i,
    input  logic [3:0]             req_wmask_i,
    input  logic [31:0]            req_wdata_i,

    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_error_o,

    output logic                   host_a_valid_o,
    output logic [2:0]             host_a_opcode_o,
    output logic [2:0]             host_a_param_o,
    output logic [1:0]             host_a_size_o,
    output logic [SourceWidth-1:0] host_a_source_o,
    output logic [AddrWidth-1:0]   host_a_address_o,
    output logic [3:0]             host_a_mask_o,
    output logic                   host_a_corrupt_o,
    output logic [31:0]            host_a_data_o,
    input  logic                   host_a_ready_i,

    input  logic                   host_d_valid_i,
    input  logic [2:0]             host_d_opcode_i,
    input  logic [2:0]             host_d_param_i,
    input  logic [1:0]             host_d_size_i,
    input  logic [SourceWidth-1:0] host_d_source_i,
    input  logic                   host_d_sink_i,
    input  logic                   host_d_denied_i,
    input  logic                   host_d_corrupt_i,
    input  logic [31:0]            host_d_data_i,
    output logic                   host_d_ready_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        WAIT_D = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             a_opcode_q, a_opcode_d;
    logic [AddrWidth-1:0]   a_address_q, a_address_d;
    logic [3:0]             a_mask_q, a_mask_d;
    logic [31:0]            a_data_q, a_data_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   error_q, error_d;

    // Response routing fields are deliberately ignored with one outstanding request.
    logic unused_d_fields;
    assign unused_d_fields = ^{host_d_param_i, host_d_size_i, host_d_source_i, host_d_sink_i};

    function automatic logic [2:0] a_opcode_for(input logic we, input logic [3:0] mask);
        logic [2:0] op;
        if (!we) begin
            op = Get;
        end else if (mask == 4'hF) begin
            op = PutFullData;
        end else begin
            op = PutPartialData;
        end
        return op;
    endfunction

    // Next-state, request latching and response capture.
    always_comb begin
        state_d     = state_q;
        a_opcode_d  = a_opcode_q;
        a_address_d = a_address_q;
        a_mask_d    = a_mask_q;
        a_data_d    = a_data_q;
        rdata_d     = rdata_q;
        error_d     = error_q;

        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    a_opcode_d  = a_opcode_for(req_we_i, req_wmask_i);
                    a_address_d = {req_addr_i, 2'b00};
                    a_mask_d    = req_we_i ? req_wmask_i : 4'hF;
                    a_data_d    = req_we_i ? req_wdata_i : 32'h0000_0000;
                    rdata_d     = 32'h0000_0000;
                    error_d     = 1'b0;
                    // An empty write mask completes locally without touching the bus.
                    if (req_we_i && (req_wmask_i == 4'h0)) begin
                        state_d = RESP;
                    end else begin
                        state_d = SEND_A;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SEND_A: begin
                if (host_a_ready_i) begin
                    state_d = WAIT_D;
                end else begin
                    state_d = SEND_A;
                end
            end
            WAIT_D: begin
                if (host_d_valid_i) begin
                    rdata_d = (host_d_opcode_i == AccessAckData) ? host_d_data_i : 32'h0000_0000;
                    error_d = host_d_denied_i |
                              (host_d_corrupt_i & (host_d_opcode_i == AccessAckData));
                    state_d = RESP;
                end else begin
                    state_d = WAIT_D;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            a_opcode_q  <= 3'h0;
            a_address_q <= '0;
            a_mask_q    <= 4'h0;
            a_data_q    <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_opcode_q  <= a_opcode_d;
            a_address_q <= a_address_d;
            a_mask_q    <= a_mask_d;
            a_data_q    <= a_data_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
        end
    end

    assign req_ready_o      = (state_q == IDLE);
    assign rsp_valid_o      = (state_q == RESP);
    assign rsp_rdata_o      = rdata_q;
    assign rsp_error_o      = error_q;

    assign host_a_valid_o   = (state_q == SEND_A);
    assign host_a_opcode_o  = a_opcode_q;
    assign host_a_param_o   = 3'h0;
    assign host_a_size_o    = TlSizeWord;
    assign host_a_source_o  = SourceId;
    assign host_a_address_o = a_address_q;
    assign host_a_mask_o    = a_mask_q;
    assign host_a_corrupt_o = 1'b0;
    assign host_a_data_o    = a_data_q;

    // Stray beats left over from an abandoned transaction drain in IDLE.
    assign host_d_ready_o   = (state_q == IDLE) || (state_q == WAIT_D);

endmodule

// File: tb/tb_tl_bram_host.sv
// Directed bench for tl_bram_host: a transaction-level expectation queue
// checked every meaningful cycle, plus literal expectations per scenario.
module tb_tl_bram_host;

    localparam int AW = 12;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_ready_o, req_we;
    logic [9:0]  req_addr;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;
    logic        rsp_valid_o, rsp_ready, rsp_error_o;
    logic [31:0] rsp_rdata_o;
    logic        a_valid, a_corrupt, a_ready, a_source;
    logic [2:0]  a_opcode, a_param;
    logic [1:0]  a_size;
    logic [11:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid, d_source, d_sink, d_denied, d_corrupt, d_ready;
    logic [2:0]  d_opcode, d_param;
    logic [1:0]  d_size;
    logic [31:0] d_data;

    tl_bram_host #(.AddrWidth(AW), .SourceWidth(1), .SourceId(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wmask_i(req_wmask), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
        .host_a_valid_o(a_valid), .host_a_opcode_o(a_opcode), .host_a_param_o(a_param),
        .host_a_size_o(a_size), .host_a_source_o(a_source), .host_a_address_o(a_address),
        .host_a_mask_o(a_mask), .host_a_corrupt_o(a_corrupt), .host_a_data_o(a_data),
        .host_a_ready_i(a_ready),
        .host_d_valid_i(d_valid), .host_d_opcode_i(d_opcode), .host_d_param_i(d_param),
        .host_d_size_i(d_size), .host_d_source_i(d_source), .host_d_sink_i(d_sink),
        .host_d_denied_i(d_denied), .host_d_corrupt_i(d_corrupt), .host_d_data_i(d_data),
        .host_d_ready_o(d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [2:0] op; logic [11:0] addr; logic [3:0] mask; logic [31:0] data; } a_exp_t;
    typedef struct { logic [31:0] rdata; logic err; } r_exp_t;
    a_exp_t a_q[$];
    r_exp_t r_q[$];

    logic [2:0]  cap_op;
    logic [11:0] cap_addr;
    logic [3:0]  cap_mask;
    logic [1:0]  cap_size;
    logic [31:0] cap_data, cap_rdata;
    logic        cap_err;
    int          lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the visible channels against the expectation queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid) begin
                check("a_expected", 32'(a_q.size() != 0), 32'd1);
                if (a_q.size() != 0) begin
                    check("a_opcode", a_opcode, a_q[0].op);
                    check("a_address", a_address, a_q[0].addr);
                    check("a_mask", a_mask, a_q[0].mask);
                    check("a_data", a_data, a_q[0].data);
                    check("a_size", a_size, 32'd2);
                    check("a_param", a_param, 32'd0);
                    check("a_corrupt", a_corrupt, 32'd0);
                    check("a_source", a_source, 32'd0);
                    check("a_req_ready", req_ready_o, 32'd0);
                    check("a_d_ready", d_ready, 32'd0);
                    if (a_ready) a_q.pop_front();
                end
            end
            if (rsp_valid_o) begin
                check("rsp_expected", 32'(r_q.size() != 0), 32'd1);
                if (r_q.size() != 0) begin
                    check("rsp_rdata", rsp_rdata_o, r_q[0].rdata);
                    check("rsp_error", rsp_error_o, r_q[0].err);
                    check("rsp_d_ready", d_ready, 32'd0);
                    check("rsp_req_ready", req_ready_o, 32'd0);
                    if (rsp_ready) r_q.pop_front();
                end
            end
        end
    end

    task automatic do_txn(input logic we, input logic [9:0] waddr, input logic [3:0] mask,
                          input logic [31:0] wdata, input int a_stall, input int d_delay,
                          input logic [2:0] dop, input logic [31:0] ddat, input logic den,
                          input logic cor, input int r_stall);
        a_exp_t ea;
        r_exp_t er;
        bit     has_a;
        int     start, n;
        has_a = !(we && (mask == 4'h0));
        if (has_a) begin
            ea.op   = !we ? 3'd4 : ((mask == 4'hF) ? 3'd0 : 3'd1);
            ea.addr = {waddr, 2'b00};
            ea.mask = we ? mask : 4'hF;
            ea.data = we ? wdata : 32'h0;
            a_q.push_back(ea);
            er.rdata = (dop == 3'd1) ? ddat : 32'h0;
            er.err   = den | (cor & (dop == 3'd1));
        end else begin
            er.rdata = 32'h0;
            er.err   = 1'b0;
        end
        r_q.push_back(er);
        start     = cyc;
        req_valid = 1'b1; req_we = we; req_addr = waddr; req_wmask = mask; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (has_a) begin
            cap_op = a_opcode; cap_addr = a_address; cap_mask = a_mask;
            cap_size = a_size; cap_data = a_data;
            repeat (a_stall) begin
                check("busy_req_ready", req_ready_o, 32'd0);
                @(posedge clk); #1;
            end
            a_ready = 1'b1;
            n = 0;
            while (!a_valid && n < 20) begin @(posedge clk); #1; n++; end
            check("a_valid_seen", a_valid, 32'd1);
            @(posedge clk); #1;
            a_ready = 1'b0;
            repeat (d_delay) begin
                check("wait_d_ready", d_ready, 32'd1);
                @(posedge clk); #1;
            end
            d_valid = 1'b1; d_opcode = dop; d_data = ddat; d_denied = den; d_corrupt = cor;
            d_source = 1'($urandom); d_sink = 1'($urandom); d_param = 3'($urandom); d_size = 2'd2;
            check("wait_d_ready", d_ready, 32'd1);
            @(posedge clk); #1;
            d_valid = 1'b0;
        end
        n = 0;
        while (!rsp_valid_o && n < 20) begin @(posedge clk); #1; n++; end
        check("rsp_seen", rsp_valid_o, 32'd1);
        lat = cyc - start;
        check("latency", lat, has_a ? (3 + a_stall + d_delay) : 1);
        cap_rdata = rsp_rdata_o; cap_err = rsp_error_o;
        repeat (r_stall) begin
            check("rsp_held", rsp_valid_o, 32'd1);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("req_ready_after", req_ready_o, 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_rsp_valid", rsp_valid_o, 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        check("rst_error", rsp_error_o, 32'd0);
        check("rst_a_valid", a_valid, 32'd0);
        check("rst_a_fields", {a_opcode, a_address, a_mask}, 32'd0);
        check("rst_a_data", a_data, 32'd0);
        check("rst_req_ready", req_ready_o, 32'd1);
        check("rst_d_ready", d_ready, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'h0; req_wmask = 4'h0;
        req_wdata = 32'h0; rsp_ready = 1'b0; a_ready = 1'b0; d_valid = 1'b0; d_opcode = 3'h0;
        d_param = 3'h0; d_size = 2'h0; d_source = 1'b0; d_sink = 1'b0; d_denied = 1'b0;
        d_corrupt = 1'b0; d_data = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Read of word 1 answered immediately with data.
        do_txn(1'b0, 10'h001, 4'h0, 32'h0, 0, 0, 3'd1, 32'hDEADBEEF, 1'b0, 1'b0, 0);
        check("rd_op", cap_op, 32'd4);
        check("rd_addr", cap_addr, 32'h004);
        check("rd_mask", cap_mask, 32'hF);
        check("rd_size", cap_size, 32'd2);
        check("rd_rdata", cap_rdata, 32'hDEADBEEF);
        check("rd_err", cap_err, 32'd0);
        check("rd_lat", lat, 32'd3);

        // Full write; a stray data word on AccessAck must not leak to rdata.
        do_txn(1'b1, 10'h010, 4'hF, 32'h12345678, 0, 1, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        check("wf_op", cap_op, 32'd0);
        check("wf_data", cap_data, 32'h12345678);
        check("wf_rdata", cap_rdata, 32'd0);

        do_txn(1'b1, 10'h3FF, 4'h3, 32'hA5A5_0F0F, 0, 0, 3'd0, 32'h0, 1'b0, 1'b0, 0);
        check("wp_op", cap_op, 32'd1);
        check("wp_mask", cap_mask, 32'h3);
        check("wp_addr", cap_addr, 32'hFFC);

        do_txn(1'b1, 10'h005, 4'h0, 32'hCAFE_F00D, 0, 0, 3'd0, 32'h0, 1'b0, 1'b0, 0);
        check("wz_lat", lat, 32'd1);
        check("wz_rdata", cap_rdata, 32'd0);

        do_txn(1'b0, 10'h0AA, 4'h0, 32'h0, 5, 2, 3'd1, 32'h0BAD_C0DE, 1'b0, 1'b0, 4);
        check("bp_lat", lat, 32'd10);
        check("bp_rdata", cap_rdata, 32'h0BAD_C0DE);

        do_txn(1'b0, 10'h002, 4'h0, 32'h0, 0, 0, 3'd1, 32'h1111_2222, 1'b1, 1'b0, 0);
        check("denied_err", cap_err, 32'd1);
        do_txn(1'b0, 10'h003, 4'h0, 32'h0, 0, 0, 3'd1, 32'h3333_4444, 1'b0, 1'b1, 1);
        check("corrupt_err", cap_err, 32'd1);
        check("corrupt_rdata", cap_rdata, 32'h3333_4444);
        do_txn(1'b1, 10'h004, 4'hC, 32'h5555_6666, 0, 0, 3'd0, 32'h0, 1'b0, 1'b1, 0);
        check("ack_corrupt_err", cap_err, 32'd0);

        // Reset while waiting for D, then a late beat lands in IDLE.
        a_q.push_back('{op: 3'd4, addr: 12'h020, mask: 4'hF, data: 32'h0});
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h008;
        @(posedge clk); #1;
        req_valid = 1'b0; a_ready = 1'b1;
        @(posedge clk); #1;
        a_ready = 1'b0;
        check("mid_d_ready", d_ready, 32'd1);
        rst_n = 1'b0;
        a_q.delete();
        r_q.delete();
        #2;
        check_reset_values();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        d_valid = 1'b1; d_opcode = 3'd1; d_data = 32'hBAAD_F00D; d_denied = 1'b0; d_corrupt = 1'b0;
        check("stray_d_ready", d_ready, 32'd1);
        @(posedge clk); #1;
        d_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_no_rsp", rsp_valid_o, 32'd0);
            check("stray_req_ready", req_ready_o, 32'd1);
            @(posedge clk); #1;
        end
        do_txn(1'b0, 10'h009, 4'h0, 32'h0, 0, 0, 3'd1, 32'h7777_8888, 1'b0, 1'b0, 0);
        check("post_rst_rdata", cap_rdata, 32'h7777_8888);
        check("post_rst_addr", cap_addr, 32'h024);

        repeat (2) @(posedge clk);
        #1;
        check("model_drained", a_q.size() + r_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl_bram_host.md
# tl_bram_host

Host-side bridge that turns a simple single-word register request port into TileLink-UL transactions on a 32-bit host link. It lets a small controller (debug/boot sequencer, test master) access any device behind the TileLink crossbar, such as the GPIO block or other BRAM-style terminated devices. Only one transaction is outstanding at a time. Responses are registered and handed back through a valid/ready response port.

## Interface

Parameters:
- AddrWidth, 12: TileLink byte address width.
- SourceWidth, 1: TileLink source ID width.
- SourceId, 0: constant value driven on a_source.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request accepted when valid && ready.
- req_we_i  input  1  1 = write, 0 = read.
- req_addr_i  input  AddrWidth-2  word address; the byte address is {req_addr_i, 2'b00}.
- req_wmask_i  input  4  byte write mask; ignored for reads.
- req_wdata_i  input  32  write data.
- rsp_valid_o  output  1  response valid; held until rsp_ready_i.
- rsp_ready_i  input  1  response accepted.
- rsp_rdata_o  output  32  read data; 0 for writes.
- rsp_error_o  output  1  set when d_denied or d_corrupt was seen.
- host_*  TileLink host port, declared with TL_DECLARE_HOST_PORT(32, AddrWidth, SourceWidth, 1, host).
  - A-channel outputs: valid, opcode, param, size, source, address, mask, corrupt, data; a_ready is an input.
  - D-channel inputs: valid, opcode, param, size, source, sink, denied, corrupt, data; d_ready is an output.

## Operation

- State machine states: IDLE, SEND_A, WAIT_D, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req handshake, latch we, addr, wmask and wdata.
  - Read, or write with a nonzero mask: go to SEND_A.
  - Write with mask 4'b0000: no TileLink traffic. Go directly to RESP with rdata 0 and error 0.
- SEND_A:
  - a_valid = 1. A fields are stable from the latches until a_ready.
  - On a_ready, go to WAIT_D.
- A-channel encoding:
  - Read: Get (4), mask 4'hF.
  - Write with mask 4'hF: PutFullData (0).
  - Any other nonzero mask: PutPartialData (1) with the given mask.
  - Always: a_size = 2, a_param = 0, a_corrupt = 0, a_source = SourceId.
  - a_data = latched wdata; 0 for Get.
- WAIT_D:
  - d_ready = 1.
  - On d_valid, latch:
    - rdata = d_data if d_opcode is AccessAckData (1), else 0.
    - error = d_denied | (d_corrupt && d_opcode == AccessAckData).
  - Then go to RESP.
  - d_source, d_size, d_param and d_sink are not checked.
- RESP:
  - rsp_valid_o = 1. rdata and error are stable.
  - On rsp_ready_i, go to IDLE.
- d_ready is also 1 in IDLE. Stray D beats in IDLE (for example after reset mid-transaction) are accepted and discarded.
- d_ready is 0 in SEND_A and RESP.
- Reset values:
  - State is IDLE.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_error_o = 0.
  - a_valid = 0, all A fields = 0.
  - req_ready_o = 1, d_ready = 1.
- Reset mid-transaction: an A request is abandoned immediately, with no A/D protocol check. The response is never produced.

## Timing

- Request accepted in cycle 0. a_valid is asserted in cycle 1.
- With a_ready held high, the A handshake completes in cycle 1 and the state is WAIT_D from cycle 2.
- A D beat accepted in cycle N gives rsp_valid_o in cycle N+1. Minimum round trip is 3 cycles from request to response (D in cycle 2).
- Zero-mask write: rsp_valid_o in cycle 1.
- req_ready_o is 0 from cycle 1 until the cycle after the response handshake. Throughput is at most one transaction per 4 cycles.
- All outputs come directly from registers or state decode. There is no combinational path from any input to any output.

## Structure

- TileLink A/D opcode enums and size constants come from the shared TileLink package used by all TL blocks (tl_pkg). Nothing new is added there.
- The state enum is local to the module.
- Single flat module; no sub-module.

## Test plan

- Read at word 0x001, device returns AccessAckData with 0xDEADBEEF one cycle after A:
  - A carries Get, address 0x004, mask F, size 2.
  - Response: rdata 0xDEADBEEF, error 0, 3 cycles after the request.
- Write 0x12345678 with mask F:
  - A carries PutFullData with data 0x12345678.
  - AccessAck returns rdata 0, error 0.
- Write with mask 0011:
  - A carries PutPartialData with mask 3.
  - Zero-mask write: no a_valid pulse, rsp_valid_o next cycle.
- Backpressure:
  - a_ready low for 5 cycles: A fields stable; req_ready_o stays 0.
  - rsp_ready_i low for 4 cycles: response held stable, d_ready = 0.
- Read answered with d_denied = 1: rsp_error_o = 1. AccessAckData with d_corrupt = 1: rsp_error_o = 1.
- rst_ni asserted while in WAIT_D, then a late D beat arrives in IDLE:
  - The beat is accepted and discarded.
  - No rsp_valid_o is produced.
  - The next read completes normally.
